// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Byte FIFO between the CPU store path and the UART transmitter.
//                Accepts one byte per cycle and launches bytes one at a time
//                using the tx_data / tx_enable / tx_status handshake, with a
//                timeout on the launch acknowledge.
//                Optional macro UART_TX_FIFO_OVF_CNT_EN adds the overflow
//                outputs ovf_sticky and ovf_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int DEPTH_LOG2   = 4,
   parameter int BUSY_TIMEOUT = 1023,
   parameter int TMO_W        = 10
) (
   input  logic                  sysclk,
   input  logic                  reset,
   input  logic [7:0]            wr_data,
   input  logic                  wr_en,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic [7:0]            uart_tx_data,
   output logic                  uart_tx_enable,
   input  logic                  uart_tx_status,
   output logic                  busy,
   output logic                  tmo_err
`ifdef UART_TX_FIFO_OVF_CNT_EN
   ,
   output logic                  ovf_sticky,
   output logic [7:0]            ovf_count
`endif
);

   localparam int                  C_DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] C_LVL_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] C_LVL_ONE   = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2:0] C_LVL_ZERO  = '0;
   localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = DEPTH_LOG2'(1);
   localparam logic [TMO_W-1:0]    C_TMO_ONE   = TMO_W'(1);
   // The counter holds (cycles spent in ACK - 1), so this value means the
   // timeout has elapsed BUSY_TIMEOUT cycles after the launch cycle.
   localparam logic [TMO_W-1:0]    C_TMO_LAST  = TMO_W'(BUSY_TIMEOUT - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_ACK    = 2'd2;
   localparam logic [1:0] S_DRAIN  = 2'd3;

   logic [7:0]            r_mem [C_DEPTH];
   logic [DEPTH_LOG2-1:0] r_wptr;
   logic [DEPTH_LOG2-1:0] r_rptr;
   logic [DEPTH_LOG2:0]   r_level;
   logic                  r_full;
   logic                  r_empty;
   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic [TMO_W-1:0]      r_tmo_cnt;
   logic                  w_pop;
   logic                  w_wr_accept;
   logic [DEPTH_LOG2:0]   w_level_nxt;

   // A pop only happens on the IDLE->LAUNCH transition; a full FIFO still
   // takes a write in the cycle it pops.
   assign w_pop       = (r_state == S_IDLE) && !r_empty && uart_tx_status;
   assign w_wr_accept = wr_en && (!r_full || w_pop);

   assign full  = r_full;
   assign empty = r_empty;
   assign level = r_level;

   // Occupancy after this cycle's write/pop combination
   always_comb begin
      w_level_nxt = r_level;
      if (w_wr_accept && !w_pop)
         w_level_nxt = r_level + C_LVL_ONE;
      else if (!w_wr_accept && w_pop)
         w_level_nxt = r_level - C_LVL_ONE;
   end

   // Byte storage; contents need no reset because the pointers define validity
   always_ff @(posedge sysclk) begin
      if (!reset && w_wr_accept)
         r_mem[r_wptr] <= wr_data;
   end

   // Pointers, level and the registered full/empty flags
   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_wr_accept)
            r_wptr <= r_wptr + C_PTR_ONE;
         if (w_pop)
            r_rptr <= r_rptr + C_PTR_ONE;
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == C_LVL_FULL);
         r_empty <= (w_level_nxt == C_LVL_ZERO);
      end
   end

   // Transmit data register: only a pop changes it, so it stays stable while
   // the transmitter samples it on its own baud tick
   always_ff @(posedge sysclk) begin
      if (reset)
         uart_tx_data <= 8'h00;
      else if (w_pop)
         uart_tx_data <= r_mem[r_rptr];
   end

   // FSM state register
   always_ff @(posedge sysclk) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // FSM next-state logic; a falling status in ACK wins over the timeout
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (!r_empty && uart_tx_status) w_state_nxt = S_LAUNCH;
         S_LAUNCH: w_state_nxt = S_ACK;
         S_ACK: begin
            if (!uart_tx_status)
               w_state_nxt = S_DRAIN;
            else if (r_tmo_cnt == C_TMO_LAST)
               w_state_nxt = S_IDLE;
         end
         S_DRAIN:  if (uart_tx_status) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs decoded from the registered state
   always_comb begin
      uart_tx_enable = (r_state == S_LAUNCH);
      busy           = (r_state != S_IDLE);
      tmo_err        = (r_state == S_ACK) && uart_tx_status && (r_tmo_cnt == C_TMO_LAST);
   end

   // Acknowledge timeout counter, cleared in LAUNCH and advanced in ACK
   always_ff @(posedge sysclk) begin
      if (reset)
         r_tmo_cnt <= '0;
      else if (r_state == S_LAUNCH)
         r_tmo_cnt <= '0;
      else if (r_state == S_ACK)
         r_tmo_cnt <= r_tmo_cnt + C_TMO_ONE;
   end

`ifdef UART_TX_FIFO_OVF_CNT_EN
   logic w_drop;
   assign w_drop = wr_en && r_full && !w_pop;

   // Overflow flag and saturating drop counter, cleared only by reset
   always_ff @(posedge sysclk) begin
      if (reset) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= 8'h00;
      end else if (w_drop) begin
         ovf_sticky <= 1'b1;
         if (ovf_count != 8'hFF)
            ovf_count <= ovf_count + 8'h01;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo. Expected launch bytes
//                are queued when writes are issued; a monitor pops and
//                compares them on every uart_tx_enable pulse. A transmitter
//                model drives uart_tx_status.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

   localparam int T = 1023;

   logic       clk;
   logic       reset;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       full;
   logic       empty;
   logic [4:0] level;
   logic [7:0] uart_tx_data;
   logic       uart_tx_enable;
   logic       status;
   logic       busy;
   logic       tmo_err;
`ifdef UART_TX_FIFO_OVF_CNT_EN
   logic       ovf_sticky;
   logic [7:0] ovf_count;
`endif

   uart_tx_fifo #(.DEPTH_LOG2(4), .BUSY_TIMEOUT(T), .TMO_W(10)) dut (
      .sysclk         (clk),
      .reset          (reset),
      .wr_data        (wr_data),
      .wr_en          (wr_en),
      .full           (full),
      .empty          (empty),
      .level          (level),
      .uart_tx_data   (uart_tx_data),
      .uart_tx_enable (uart_tx_enable),
      .uart_tx_status (status),
      .busy           (busy),
      .tmo_err        (tmo_err)
`ifdef UART_TX_FIFO_OVF_CNT_EN
      ,
      .ovf_sticky     (ovf_sticky),
      .ovf_count      (ovf_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard and monitor state
   logic [7:0] sb[$];
   int         launch_cnt = 0;
   int         last_launch_cyc = 0;
   int         tmo_cnt = 0;
   int         tmo_cyc = 0;
   logic [7:0] cur_byte = 8'h00;
   logic       prev_en = 1'b0;
   int         drops = 0;

   // Transmitter model controls
   bit no_ack   = 1'b0;
   bit rnd_tx   = 1'b0;
   int ack_dly  = 1;
   int busy_len = 20;
   int tx_d;
   int tx_b;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Monitor: every launch pops and checks the next expected byte
   always @(negedge clk) begin
      if (!reset) begin
         if (uart_tx_enable) begin
            chk("enable_width", {31'b0, prev_en}, 32'd0);
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_launch: got byte %0h required no launch", uart_tx_data);
            end else begin
               chk("launch_data", {24'b0, uart_tx_data}, {24'b0, sb.pop_front()});
            end
            cur_byte        = uart_tx_data;
            launch_cnt      = launch_cnt + 1;
            last_launch_cyc = cyc;
         end else if (busy) begin
            chk("data_hold", {24'b0, uart_tx_data}, {24'b0, cur_byte});
         end
         if (tmo_err) begin
            tmo_cnt = tmo_cnt + 1;
            tmo_cyc = cyc;
         end
      end
      prev_en = uart_tx_enable;
   end

   // Transmitter model: after a launch goes busy (status 0) for a while
   initial begin
      forever begin
         @(negedge clk);
         if (uart_tx_enable && !reset && !no_ack) begin
            tx_d = rnd_tx ? int'($urandom_range(0, 3))  : ack_dly;
            tx_b = rnd_tx ? int'($urandom_range(1, 30)) : busy_len;
            repeat (tx_d) @(negedge clk);
            status = 1'b0;
            repeat (tx_b) @(negedge clk);
            status = 1'b1;
         end
      end
   end

   task automatic wait_drain(input string nm, input int bound);
      bit done = 1'b0;
      for (int i = 0; i < bound && !done; i++) begin
         tick();
         if (sb.size() == 0 && !busy && status && empty) done = 1'b1;
      end
      chk({nm, "_drained"}, {31'b0, done}, 32'd1);
      chk({nm, "_level0"}, {27'b0, level}, 32'd0);
   endtask

   task automatic push_write(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      if (sb.size() < 16) sb.push_back(d);
      else drops++;
   endtask

   initial begin
      int lc0;
      int t0;
      int n;
      bit seen;
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      status  = 1'b1;

      // 1. reset state
      repeat (3) tick();
      chk("rst_empty", {31'b0, empty}, 32'd1);
      chk("rst_full", {31'b0, full}, 32'd0);
      chk("rst_level", {27'b0, level}, 32'd0);
      chk("rst_enable", {31'b0, uart_tx_enable}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_data", {24'b0, uart_tx_data}, 32'h00);
`ifdef UART_TX_FIFO_OVF_CNT_EN
      chk("rst_ovf_cnt", {24'b0, ovf_count}, 32'd0);
`endif
      reset = 1'b0;
      tick();

      // 2. single-byte latency
      ack_dly = 1; busy_len = 20;
      push_write(8'hA5);
      tick();
      wr_en = 1'b0;
      chk("lat_empty_n1", {31'b0, empty}, 32'd0);
      chk("lat_enable_n1", {31'b0, uart_tx_enable}, 32'd0);
      tick();
      chk("lat_enable_n2", {31'b0, uart_tx_enable}, 32'd1);
      chk("lat_data_n2", {24'b0, uart_tx_data}, 32'hA5);
      repeat (10) tick();
      chk("busy_while_tx", {31'b0, busy}, 32'd1);
      wait_drain("t2", 200);

      // 3. overflow with status held low
      status = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         tick();
         push_write(i[7:0]);
      end
      tick();
      wr_en = 1'b0;
      tick();
      chk("ovf_level", {27'b0, level}, 32'd16);
      chk("ovf_full", {31'b0, full}, 32'd1);
      chk("ovf_drops", drops, 32'd1);
`ifdef UART_TX_FIFO_OVF_CNT_EN
      chk("ovf_count1", {24'b0, ovf_count}, 32'd1);
      chk("ovf_sticky1", {31'b0, ovf_sticky}, 32'd1);
`endif
      busy_len = 5;
      status   = 1'b1;
      wait_drain("t3", 1000);

      // 4. write on the pop cycle of a full FIFO
      status = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         push_write(8'($urandom));
      end
      tick();
      wr_en = 1'b0;
      tick();
      chk("fill_full", {31'b0, full}, 32'd1);
      status  = 1'b1;
      wr_en   = 1'b1;
      wr_data = 8'h77;
      sb.push_back(8'h77);
      tick();
      wr_en = 1'b0;
      chk("popwr_level", {27'b0, level}, 32'd16);
      chk("popwr_full", {31'b0, full}, 32'd1);
      wait_drain("t4", 1000);

      // Random bursts against a stalled transmitter, then drain
      rnd_tx = 1'b1;
      for (int r = 0; r < 4; r++) begin
         status = 1'b0;
         n = int'($urandom_range(5, 24));
         for (int i = 0; i < n; i++) begin
            tick();
            if ($urandom_range(0, 3) != 0) push_write(8'($urandom));
            else wr_en = 1'b0;
         end
         tick();
         wr_en = 1'b0;
         tick();
         chk("rnd_level", {27'b0, level}, sb.size());
         chk("rnd_full", {31'b0, full}, {31'b0, sb.size() == 16});
         status = 1'b1;
         wait_drain("rnd_burst", 3000);
      end
`ifdef UART_TX_FIFO_OVF_CNT_EN
      chk("rnd_ovf_count", {24'b0, ovf_count}, (drops > 255) ? 255 : drops);
`endif

      // Free-running random traffic, writes gated so none is dropped
      for (int i = 0; i < 400; i++) begin
         tick();
         if ($urandom_range(0, 2) == 0 && sb.size() < 16) push_write(8'($urandom));
         else wr_en = 1'b0;
      end
      tick();
      wr_en = 1'b0;
      wait_drain("rnd_free", 3000);
      rnd_tx = 1'b0;

      // 5. acknowledge timeout
      no_ack   = 1'b1;
      busy_len = 8;
      t0  = tmo_cnt;
      lc0 = launch_cnt;
      push_write(8'h3C);
      tick();
      push_write(8'hC3);
      tick();
      wr_en = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < T + 50 && !seen; i++) begin
         tick();
         if (tmo_cnt != t0) seen = 1'b1;
      end
      no_ack = 1'b0;
      chk("tmo_seen", {31'b0, seen}, 32'd1);
      chk("tmo_delay", tmo_cyc - last_launch_cyc, T);
      chk("tmo_launches", launch_cnt - lc0, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         if (launch_cnt == lc0 + 2) seen = 1'b1;
      end
      chk("tmo_relaunch", last_launch_cyc - tmo_cyc, 32'd2);
      wait_drain("t5", 500);
      chk("tmo_once", tmo_cnt - t0, 32'd1);

      // 6. reset during DRAIN with bytes queued
      ack_dly  = 1;
      busy_len = 60;
      for (int i = 0; i < 6; i++) begin
         push_write(8'hE0 + i[7:0]);
         tick();
      end
      wr_en = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (!status) seen = 1'b1;
         else tick();
      end
      chk("drain_reached", {31'b0, seen}, 32'd1);
      repeat (3) tick();
      chk("pre_rst_level", {27'b0, level}, 32'd5);
      chk("pre_rst_busy", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      sb.delete();
      tick();
      reset = 1'b0;
      chk("mid_rst_level", {27'b0, level}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_empty", {31'b0, empty}, 32'd1);
`ifdef UART_TX_FIFO_OVF_CNT_EN
      chk("mid_rst_ovf", {24'b0, ovf_count}, 32'd0);
`endif
      lc0 = launch_cnt;
      repeat (100) tick();
      chk("no_launch_after_rst", launch_cnt, lc0);
      chk("final_status", {31'b0, status}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
